// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the boot-time instruction
// memory loader.
//   LoaderState  - loader FSM states (LEN, DATA, SUM, DONE, ERR)
//   IMEM_DEPTH   - instruction memory depth in 32-bit words
//   IMEM_ADDR_W  - word address width, $clog2(IMEM_DEPTH)
package imem_loader_pkg;

  localparam int IMEM_DEPTH  = 32768;
  localparam int IMEM_ADDR_W = 15;

  typedef enum logic [2:0] {
    LEN,
    DATA,
    SUM,
    DONE,
    ERR
  } LoaderState;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream input, instruction memory write port and
// loader status, bundled together.
//   rxValid/rxData           - byte strobe and byte from the UART receiver
//   memWe/memAddr/memWdata   - instruction memory write port
//   coreRst/busy/done/error  - core reset and loader status
// Modports:
//   master - the stream source / system side (drives rxValid, rxData)
//   slave  - the loader (consumes the stream, drives memory and status)
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
);

  logic              rxValid;
  logic [7:0]        rxData;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic              coreRst;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output rxValid, rxData,
    input  memWe, memAddr, memWdata, coreRst, busy, done, error
  );

  modport slave (
    input  rxValid, rxData,
    output memWe, memAddr, memWdata, coreRst, busy, done, error
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: collects bytes into a little-endian 32-bit word.
//   clk, rst    - clock, asynchronous active-high reset
//   clr         - restart at byte 0 (used on every loader state change)
//   in_valid    - in_byte is accepted this cycle
//   in_byte     - incoming byte
//   word_valid  - this cycle's byte completes a word (one cycle)
//   word        - completed word; byte k sits in bits [8k+7:8k]
// The word is presented combinationally together with its 4th byte so the
// consumer can register it on the very edge that captures that byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  // Only the first three bytes need storage; the fourth is the live input.
  logic [23:0] shift_reg;
  logic [1:0]  cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (clr) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (in_valid) begin
      shift_reg <= {in_byte, shift_reg[23:8]};
      cnt_reg   <= cnt_reg + 2'd1;
    end
  end

  assign word_valid = in_valid && (cnt_reg == 2'd3);
  assign word       = {in_byte, shift_reg};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the instruction memory. Receives
// <N:4 bytes LE> <N words LE> <checksum byte> and writes the words to
// addresses 0..N-1, holding the core in reset until the image checks out.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - imem_loader_if slave: rxValid/rxData in; memWe/memAddr/
//              memWdata, coreRst, busy, done, error out
// Parameters: DEPTH (memory depth in words), ADDR_W = $clog2(DEPTH).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  LoaderState        state_reg, state_next;
  logic [31:0]       n_reg, n_next;
  logic [7:0]        sum_reg, sum_next;
  // One bit wider than the address so a full-depth image can terminate.
  logic [ADDR_W:0]   word_idx_reg, word_idx_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;

  logic              pk_valid;
  logic              pk_clr;
  logic              word_valid;
  logic [31:0]       word;

  // The packer only sees bytes of the length and data phases.
  assign pk_valid = bus.rxValid && ((state_reg == LEN) || (state_reg == DATA));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .in_valid   (pk_valid),
    .in_byte    (bus.rxData),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= LEN;
      n_reg         <= '0;
      sum_reg       <= '0;
      word_idx_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      n_reg         <= n_next;
      sum_reg       <= sum_next;
      word_idx_reg  <= word_idx_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    n_next         = n_reg;
    sum_next       = sum_reg;
    word_idx_next  = word_idx_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;

    case (state_reg)
      LEN: begin
        if (word_valid) begin
          n_next = word;
          if (word > DEPTH_W)     state_next = ERR;
          else if (word == 32'd0) state_next = SUM;
          else                    state_next = DATA;
        end
      end
      DATA: begin
        if (bus.rxValid) sum_next = sum_reg + bus.rxData;
        if (word_valid) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = word_idx_reg[ADDR_W-1:0];
          mem_wdata_next = word;
          word_idx_next  = word_idx_reg + 1'b1;
          if ((32'(word_idx_reg) + 32'd1) == n_reg) state_next = SUM;
        end
      end
      SUM: begin
        if (bus.rxValid) state_next = (bus.rxData == sum_reg) ? DONE : ERR;
      end
      default: ;
    endcase

    // Every phase change starts the packer on a fresh word boundary.
    pk_clr = (state_next != state_reg);
  end

  assign bus.memWe    = mem_we_reg;
  assign bus.memAddr  = mem_addr_reg;
  assign bus.memWdata = mem_wdata_reg;
  assign bus.busy     = (state_reg == LEN) || (state_reg == DATA) || (state_reg == SUM);
  assign bus.done     = (state_reg == DONE);
  assign bus.error    = (state_reg == ERR);
  assign bus.coreRst  = (state_reg != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader, run with a
// reduced memory depth so a full-image load stays short.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference image for the current load and the writes actually observed.
  logic [31:0] img[$];
  int          got_addr[$];
  logic [31:0] got_data[$];

  always @(negedge clk) begin
    if (!rst && bus.memWe) begin
      got_addr.push_back(int'(bus.memAddr));
      got_data.push_back(bus.memWdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/memWe"},    64'(bus.memWe),    64'd0);
    check({tag, "/memAddr"},  64'(bus.memAddr),  64'd0);
    check({tag, "/memWdata"}, 64'(bus.memWdata), 64'd0);
    check({tag, "/coreRst"},  64'(bus.coreRst),  64'd1);
    check({tag, "/busy"},     64'(bus.busy),     64'd1);
    check({tag, "/done"},     64'(bus.done),     64'd0);
    check({tag, "/error"},    64'(bus.error),    64'd0);
  endtask

  // Called away from a clock edge; returns #1 after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b, input bit b2b);
    if (!b2b) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.rxValid = 1'b1;
    bus.rxData  = b;
    @(posedge clk);
    #1;
    bus.rxValid = 1'b0;
    bus.rxData  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input bit b2b);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], b2b);
  endtask

  task automatic fill_img(input int n);
    img.delete();
    repeat (n) img.push_back($urandom);
  endtask

  function automatic logic [7:0] img_sum(input int n);
    logic [7:0]  s;
    logic [31:0] w;
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) s = s + w[8*k +: 8];
    end
    return s;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.rxValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got_addr.delete();
    got_data.delete();
  endtask

  // One full stream: length, img words, checksum byte cs; then junk bytes.
  task automatic do_load(input string tag, input logic [31:0] n, input logic [7:0] cs, input bit b2b);
    int         nw;
    bit         ok;
    logic [7:0] exp_sum;
    apply_reset();
    send_word(n, b2b);
    if (n > 32'(DEPTH)) begin
      check({tag, "/ovf_error"},   64'(bus.error),   64'd1);
      check({tag, "/ovf_busy"},    64'(bus.busy),    64'd0);
      check({tag, "/ovf_coreRst"}, 64'(bus.coreRst), 64'd1);
      check({tag, "/ovf_done"},    64'(bus.done),    64'd0);
      repeat (6) send_byte(8'($urandom), 1'b1);
      check({tag, "/ovf_writes"},      64'(got_addr.size()), 64'd0);
      check({tag, "/ovf_error_stays"}, 64'(bus.error),       64'd1);
      $display("load %s: N=0x%08h -> overflow, %0d writes", tag, n, got_addr.size());
      return;
    end
    nw = int'(n);
    for (int i = 0; i < nw; i++) begin
      send_word(img[i], b2b);
      check({tag, "/we"},    64'(bus.memWe),    64'd1);
      check({tag, "/addr"},  64'(bus.memAddr),  64'(i));
      check({tag, "/wdata"}, 64'(bus.memWdata), 64'(img[i]));
    end
    check({tag, "/busy_before_sum"}, 64'(bus.busy), 64'd1);
    check({tag, "/done_before_sum"}, 64'(bus.done), 64'd0);
    exp_sum = img_sum(nw);
    ok = (cs == exp_sum);
    send_byte(cs, b2b);
    check({tag, "/done"},    64'(bus.done),    64'(ok));
    check({tag, "/error"},   64'(bus.error),   64'(!ok));
    check({tag, "/coreRst"}, 64'(bus.coreRst), 64'(!ok));
    check({tag, "/busy"},    64'(bus.busy),    64'd0);
    check({tag, "/writes"},  64'(got_addr.size()), 64'(nw));
    if (nw > 0) begin
      @(posedge clk); #1;
      check({tag, "/we_idle"},    64'(bus.memWe),    64'd0);
      check({tag, "/addr_hold"},  64'(bus.memAddr),  64'(nw - 1));
      check({tag, "/wdata_hold"}, 64'(bus.memWdata), 64'(img[nw-1]));
    end
    repeat (5) send_byte(8'($urandom), 1'b1);
    check({tag, "/writes_after_end"}, 64'(got_addr.size()), 64'(nw));
    check({tag, "/done_sticky"},      64'(bus.done),        64'(ok));
    check({tag, "/error_sticky"},     64'(bus.error),       64'(!ok));
    $display("load %s: N=%0d cs=0x%02h exp=0x%02h -> %s, %0d writes",
             tag, nw, cs, exp_sum, ok ? "done" : "error", got_addr.size());
  endtask

  task automatic reset_mid_load();
    fill_img(5);
    apply_reset();
    send_word(32'd5, 1'b1);
    for (int i = 0; i < 3; i++) send_word(img[i], 1'b1);
    check("midrst/we_before", 64'(bus.memWe), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    got_addr.delete();
    got_data.delete();
    fill_img(1);
    send_word(32'd1, 1'b0);
    send_word(img[0], 1'b0);
    send_byte(img_sum(1), 1'b0);
    check("midrst/done",    64'(bus.done),        64'd1);
    check("midrst/coreRst", 64'(bus.coreRst),     64'd0);
    check("midrst/writes",  64'(got_addr.size()), 64'd1);
    if (got_addr.size() > 0) begin
      check("midrst/addr0", 64'(got_addr[0]), 64'd0);
      check("midrst/data0", 64'(got_data[0]), 64'(img[0]));
    end
    $display("load midrst: reset after 3 of 5 words, reload N=1 -> %0d writes, done=%0b",
             got_addr.size(), bus.done);
  endtask

  initial begin
    int          n;
    logic [7:0]  s;
    logic [7:0]  cs;
    bus.rxValid = 1'b0;
    bus.rxData  = 8'd0;
    rst = 1'b1;
    #1;
    check_reset_values("in_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("after_reset");

    img = '{32'h00000013, 32'h00100093};
    do_load("normal", 32'd2, 8'hB6, 1'b0);
    do_load("badsum", 32'd2, 8'h00, 1'b0);

    img.delete();
    do_load("ovf_8001",  32'h00008001,     8'h00, 1'b0);
    do_load("ovf_depth", 32'(DEPTH + 1),   8'h00, 1'b1);
    do_load("ovf_max",   32'hFFFFFFFF,     8'h00, 1'b1);

    do_load("empty_ok",  32'd0, 8'h00, 1'b1);
    do_load("empty_bad", 32'd0, 8'h01, 1'b1);

    fill_img(DEPTH);
    do_load("full", 32'(DEPTH), img_sum(DEPTH), 1'b1);

    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 12);
      fill_img(n);
      s = img_sum(n);
      cs = ($urandom_range(0, 3) == 0) ? (s ^ 8'(1 << $urandom_range(0, 7))) : s;
      do_load($sformatf("rand%0d", r), 32'(n), cs, 1'($urandom_range(0, 1)));
    end

    reset_mid_load();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader for the 32768-word instruction memory. It receives a byte stream from the UART receiver, packs bytes into little-endian 32-bit words and writes them to the instruction memory's write port. It holds the core in reset until the image is loaded and its checksum is verified. It sits between the UART RX block and the instruction memory, and drives the core reset.

## Interface
Parameters:
- `DEPTH`, default 32768: instruction memory depth in words.
- `ADDR_W`, default 15: word address width, equal to $clog2(DEPTH).

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `rxValid`  in  1: single-cycle strobe; `rxData` is valid this cycle.
- `rxData`  in  8: received byte.
- `memWe`  out  1: instruction memory write enable, one-cycle pulse.
- `memAddr`  out  ADDR_W: word address for `memWe`.
- `memWdata`  out  32: word to write.
- `coreRst`  out  1: core reset; high until the load completes successfully.
- `busy`  out  1: high while in LEN, DATA or SUM.
- `done`  out  1: image loaded and checksum matched (sticky).
- `error`  out  1: length overflow or checksum mismatch (sticky).

## Operation
Stream format, in order:
1. Word count N: 4 bytes, little-endian.
2. N×4 data bytes: each word little-endian, words in address order starting at 0.
3. One checksum byte: 8-bit modulo-256 sum of all data bytes. Length bytes are excluded.

State machine:
- LEN: accepts 4 bytes into N.
  - After byte 4: N > DEPTH → ERR; N == 0 → SUM; else → DATA.
- DATA: accumulates bytes into a 32-bit shift register (byte k lands in bits [8k+7:8k]) and adds each byte into `sum`.
  - After the 4th byte of a word, the word is written to `wordIdx`.
  - After word N−1 → SUM.
- SUM: one byte. Equal to `sum` → DONE; else → ERR.
- DONE and ERR are terminal until `rst`. `rxValid` is ignored there.

Rules:
- `rxValid` may be asserted every cycle. No bytes are dropped in LEN, DATA or SUM.
- `wordIdx` is ADDR_W+1 bits wide so the N == DEPTH case terminates. `memAddr` is its low ADDR_W bits. Address never wraps.
- The N counter is 32 bits. Values 0x00008001 through 0xFFFFFFFF are all overflow → ERR.

## Timing
- Reset values:
  - state = LEN, `memWe` = 0, `memAddr` = 0, `memWdata` = 0, `coreRst` = 1.
  - `busy` = 1, `done` = 0, `error` = 0.
  - Internal: N = 0, `sum` = 0, byte index = 0, `wordIdx` = 0.
- Write latency: `memWe` is high for exactly the one cycle after the edge that captured a word's 4th byte.
  - `memAddr` and `memWdata` are registered and valid in that same cycle.
  - They hold their last values when `memWe` is low.
- SUM byte captured at edge T → `done` or `error` is high from T+1.
  - On success, `coreRst` falls at T+1 and `busy` falls at T+1.
  - On error, `busy` also falls at T+1.
- Final data write and the SUM byte can arrive on consecutive cycles. The final write still completes before `done` rises.
- `rst` mid-load: all outputs return to reset values immediately. The next stream restarts at LEN with address 0. Words already written stay in memory.

## Structure
- Package `imem_loader_pkg`:
  - state enum `LoaderState` {LEN, DATA, SUM, DONE, ERR}.
  - constants `IMEM_DEPTH` = 32768 and `IMEM_ADDR_W` = 15.
- Sub-module `byte_packer`: shifts in 4 bytes and emits a 32-bit word with a one-cycle `wordValid`. It is shared by the LEN and DATA phases and cleared on state entry.
- Top module: FSM, checksum accumulator, word counter, write-port registers.

## Test plan
- **Normal load:** N = 2, words 0x00000013 and 0x00100093, checksum 0xB6 (0x13+0x93+0x10) → writes (0, 0x00000013) then (1, 0x00100093); then `done` = 1, `coreRst` = 0, `error` = 0.
- **Bad checksum:** same stream with checksum 0x00 → both writes occur; `error` = 1; `coreRst` stays 1; later bytes are ignored.
- **Length overflow:** N = 0x00008001 → `error` = 1 the cycle after the 4th length byte; no `memWe` ever.
- **Empty image:** N = 0, checksum 0x00 → `done` = 1, no writes. Same with checksum 0x01 → `error` = 1.
- **Full image, back-to-back:** N = 32768, `rxValid` asserted every cycle → 32768 writes; last address 0x7FFF; no address wrap; `done` = 1.
- **Reset mid-load:** assert `rst` after 3 words of N = 5 → all outputs at reset values. Resend a full N = 1 stream → single write to address 0; `done` = 1.
